// File: rtl/ex_stage.sv
// Execute stage: latches the ID bundle, evaluates the one-hot ALU, issues ld.w/st.w SRAM requests.
// Optional ID bypass/load-use output is enabled by defining EX_BYPASS_EN.
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ID_to_EX_valid,
  input  logic         MEM_allow_in,
  input  logic [149:0] to_EX_data,
  output logic         EX_allow_in,
  output logic         EX_to_MEM_valid,
  output logic [70:0]  to_MEM_data,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [3:0]   data_sram_wstrb,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  input  logic         data_sram_addr_ok
`ifdef EX_BYPASS_EN
  ,
  output logic [38:0]  EX_fwd_data
`endif
);

  // Handshake: a bundle moves from producer to consumer on a clock edge where the producer's
  // valid and the consumer's allow_in are both high; neither side withdraws valid while waiting.
  logic         EX_valid;
  logic         EX_ready_go;
  logic [149:0] ex_r;
  logic         req_sent;

  logic [31:0] pc, rj_value, rkd_value, imm;
  logic [11:0] alu_op;
  logic        src1_is_pc, src2_is_imm, mem_we, res_from_mem, gr_we, mem_op;
  logic [4:0]  dest;

  assign pc           = ex_r[149:118];
  assign rj_value     = ex_r[117:86];
  assign rkd_value    = ex_r[85:54];
  assign imm          = ex_r[53:22];
  assign alu_op       = ex_r[21:10];
  assign src1_is_pc   = ex_r[9];
  assign src2_is_imm  = ex_r[8];
  assign mem_we       = ex_r[7];
  assign res_from_mem = ex_r[6];
  assign dest         = ex_r[5:1];
  assign gr_we        = ex_r[0];
  assign mem_op       = mem_we | res_from_mem;

  assign EX_ready_go     = ~mem_op | req_sent | data_sram_addr_ok;
  assign EX_allow_in     = ~EX_valid | (EX_ready_go & MEM_allow_in);
  assign EX_to_MEM_valid = EX_valid & EX_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      EX_valid <= 1'b0;
      ex_r     <= '0;
    end else begin
      if (EX_allow_in) EX_valid <= ID_to_EX_valid;
      if (ID_to_EX_valid & EX_allow_in) ex_r <= to_EX_data;
    end
  end

  // req_sent remembers an accepted request so a stalled instruction never re-issues it.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sent <= 1'b0;
    end else if (EX_to_MEM_valid & MEM_allow_in) begin
      req_sent <= 1'b0;
    end else if (data_sram_req & data_sram_addr_ok & ~MEM_allow_in) begin
      req_sent <= 1'b1;
    end
  end

  logic [31:0] src1, src2, alu_result;
  logic [4:0]  sh;
  logic [31:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r;

  assign src1   = src1_is_pc  ? pc  : rj_value;
  assign src2   = src2_is_imm ? imm : rkd_value;
  assign sh     = src2[4:0];
  assign add_r  = src1 + src2;
  assign sub_r  = src1 - src2;
  assign slt_r  = {31'b0, ($signed(src1) < $signed(src2))};
  assign sltu_r = {31'b0, (src1 < src2)};
  assign sll_r  = src1 << sh;
  assign srl_r  = src1 >> sh;
  assign sra_r  = $signed(src1) >>> sh;

  always_comb begin
    alu_result = ({32{alu_op[0]}}  & add_r)
               | ({32{alu_op[1]}}  & sub_r)
               | ({32{alu_op[2]}}  & slt_r)
               | ({32{alu_op[3]}}  & sltu_r)
               | ({32{alu_op[4]}}  & (src1 & src2))
               | ({32{alu_op[5]}}  & ~(src1 | src2))
               | ({32{alu_op[6]}}  & (src1 | src2))
               | ({32{alu_op[7]}}  & (src1 ^ src2))
               | ({32{alu_op[8]}}  & sll_r)
               | ({32{alu_op[9]}}  & srl_r)
               | ({32{alu_op[10]}} & sra_r)
               | ({32{alu_op[11]}} & src2);
  end

  assign data_sram_req   = EX_valid & mem_op & ~req_sent;
  assign data_sram_wr    = mem_we;
  assign data_sram_wstrb = mem_we ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign to_MEM_data = {pc, alu_result, res_from_mem, dest, gr_we};

`ifdef EX_BYPASS_EN
  assign EX_fwd_data = {EX_valid & res_from_mem,
                        EX_valid & gr_we & (dest != 5'd0),
                        dest,
                        alu_result};
`endif

endmodule
